// File: rtl/route_path_tracer.sv
// route_path_tracer
// Converts the shortest-path engine's parent table into an ordered hop list.
// Parent links are followed from dest back to src and pushed onto an internal
// LIFO. The LIFO is then popped over a valid/ready stream, so hops leave in
// src-to-dest order.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   pt_we/pt_addr/pt_data parent-table write port (ignored while busy)
//   start/src/dest       trace request, sampled only when idle
//   hop_valid/hop_ready  hop stream handshake
//   hop_node/hop_last    current hop and final-hop marker
//   hop_count            path length in nodes
//   busy/done            activity flag and one-cycle completion pulse
//   err/err_code         failure flag and cause (1 no_path, 2 loop, 3 bad_node)
module route_path_tracer #(
   parameter int unsigned N_NODES = 32,
   parameter int unsigned NODE_W  = 5,
   parameter int unsigned PAR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pt_we,
   input  logic [NODE_W-1:0] pt_addr,
   input  logic [PAR_W-1:0]  pt_data,
   input  logic              start,
   input  logic [NODE_W-1:0] src,
   input  logic [NODE_W-1:0] dest,
   output logic              hop_valid,
   input  logic              hop_ready,
   output logic [NODE_W-1:0] hop_node,
   output logic              hop_last,
   output logic [NODE_W:0]   hop_count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned CNT_W = NODE_W + 1;

   localparam logic [1:0] E_NONE    = 2'd0;
   localparam logic [1:0] E_NO_PATH = 2'd1;
   localparam logic [1:0] E_LOOP    = 2'd2;
   localparam logic [1:0] E_BAD     = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WALK,
      S_EMIT,
      S_FIN
   } state_t;

   state_t state, state_nxt;

   logic [PAR_W-1:0]  parent [N_NODES];
   logic [NODE_W-1:0] stack  [N_NODES];

   logic [NODE_W-1:0] src_q, src_nxt;
   logic [NODE_W-1:0] cur, cur_nxt;
   // Number of entries on the stack; doubles as the stack pointer.
   logic [CNT_W-1:0]  depth, depth_nxt;

   logic              hop_valid_nxt;
   logic [NODE_W-1:0] hop_node_nxt;
   logic              hop_last_nxt;
   logic [CNT_W-1:0]  hop_count_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              err_nxt;
   logic [1:0]        err_code_nxt;

   logic              push;
   logic [PAR_W-1:0]  par;
   logic              par_neg;
   logic              par_big;
   logic [NODE_W-1:0] next_top_idx;

   // Parent entry of the node currently being walked.
   assign par     = parent[cur];
   assign par_neg = par[PAR_W-1];
   assign par_big = (par >= PAR_W'(N_NODES));

   // Entry that becomes the top of stack after one pop.
   assign next_top_idx = NODE_W'(depth - CNT_W'(2));

   // Parent table: reset to "no parent"; writes only while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_NODES; i++) begin
            parent[i] <= '1;
         end
      end else if (pt_we && !busy) begin
         parent[pt_addr] <= pt_data;
      end
   end

   // Hop LIFO storage; contents need no reset since depth gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[depth[NODE_W-1:0]] <= cur;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         src_q     <= '0;
         cur       <= '0;
         depth     <= '0;
         hop_valid <= 1'b0;
         hop_node  <= '0;
         hop_last  <= 1'b0;
         hop_count <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= E_NONE;
      end else begin
         state     <= state_nxt;
         src_q     <= src_nxt;
         cur       <= cur_nxt;
         depth     <= depth_nxt;
         hop_valid <= hop_valid_nxt;
         hop_node  <= hop_node_nxt;
         hop_last  <= hop_last_nxt;
         hop_count <= hop_count_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         err_code  <= err_code_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      src_nxt       = src_q;
      cur_nxt       = cur;
      depth_nxt     = depth;
      push          = 1'b0;
      hop_valid_nxt = hop_valid;
      hop_node_nxt  = hop_node;
      hop_last_nxt  = hop_last;
      hop_count_nxt = hop_count;
      done_nxt      = 1'b0;
      err_nxt       = err;
      err_code_nxt  = err_code;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               src_nxt       = src;
               cur_nxt       = dest;
               depth_nxt     = '0;
               hop_count_nxt = '0;
               err_nxt       = 1'b0;
               err_code_nxt  = E_NONE;
               state_nxt     = S_WALK;
            end
         end

         S_WALK: begin
            // Loop check comes before the push, so the stack cannot overflow.
            if (depth == CNT_W'(N_NODES)) begin
               err_code_nxt = E_LOOP;
               err_nxt      = 1'b1;
               done_nxt     = 1'b1;
               state_nxt    = S_FIN;
            end else begin
               push      = 1'b1;
               depth_nxt = depth + CNT_W'(1);
               if (cur == src_q) begin
                  hop_valid_nxt = 1'b1;
                  hop_node_nxt  = cur;
                  hop_last_nxt  = (depth == '0);
                  hop_count_nxt = depth + CNT_W'(1);
                  state_nxt     = S_EMIT;
               end else if (par_neg) begin
                  err_code_nxt = E_NO_PATH;
                  err_nxt      = 1'b1;
                  done_nxt     = 1'b1;
                  state_nxt    = S_FIN;
               end else if (par_big) begin
                  err_code_nxt = E_BAD;
                  err_nxt      = 1'b1;
                  done_nxt     = 1'b1;
                  state_nxt    = S_FIN;
               end else begin
                  cur_nxt = par[NODE_W-1:0];
               end
            end
         end

         S_EMIT: begin
            if (hop_ready) begin
               depth_nxt = depth - CNT_W'(1);
               if (depth == CNT_W'(1)) begin
                  hop_valid_nxt = 1'b0;
                  hop_last_nxt  = 1'b0;
                  done_nxt      = 1'b1;
                  state_nxt     = S_FIN;
               end else begin
                  hop_node_nxt = stack[next_top_idx];
                  hop_last_nxt = (depth == CNT_W'(2));
               end
            end
         end

         S_FIN: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_route_path_tracer.sv
module tb_route_path_tracer;

   localparam int unsigned N_NODES = 32;
   localparam int unsigned NODE_W  = 5;
   localparam int unsigned PAR_W   = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              pt_we;
   logic [NODE_W-1:0] pt_addr;
   logic [PAR_W-1:0]  pt_data;
   logic              start;
   logic [NODE_W-1:0] src;
   logic [NODE_W-1:0] dest;
   logic              hop_valid;
   logic              hop_ready;
   logic [NODE_W-1:0] hop_node;
   logic              hop_last;
   logic [NODE_W:0]   hop_count;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;

   route_path_tracer #(.N_NODES(N_NODES), .NODE_W(NODE_W), .PAR_W(PAR_W)) dut (
      .clk(clk), .reset(reset),
      .pt_we(pt_we), .pt_addr(pt_addr), .pt_data(pt_data),
      .start(start), .src(src), .dest(dest),
      .hop_valid(hop_valid), .hop_ready(hop_ready), .hop_node(hop_node),
      .hop_last(hop_last), .hop_count(hop_count),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural view of the parent table and the expected trace outcome.
   int mdl_par [N_NODES];
   int exp_q [$];
   int exp_ec;

   int obs_ec, obs_cnt, obs_first;

   bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   typedef struct {
      int wa0; int wv0; int wa1; int wv1;
      int s; int d; int rmode;
      int ec; int cnt; int first;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Follow parent links from d toward s; the hop list is that walk reversed.
   function automatic void model(input int s, input int d);
      int walk [$];
      int c;
      int p;
      exp_q.delete();
      exp_ec = 0;
      c = d;
      forever begin
         if (walk.size() == N_NODES) begin exp_ec = 2; break; end
         walk.push_back(c);
         if (c == s) break;
         p = mdl_par[c];
         if (p < 0) begin exp_ec = 1; break; end
         if (p >= N_NODES) begin exp_ec = 3; break; end
         c = p;
      end
      if (exp_ec == 0) begin
         for (int i = walk.size() - 1; i >= 0; i--) exp_q.push_back(walk[i]);
      end
   endfunction

   task automatic do_reset();
      reset = 1'b1; pt_we = 1'b0; start = 1'b0; hop_ready = 1'b0;
      pt_addr = '0; pt_data = '0; src = '0; dest = '0;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < N_NODES; i++) mdl_par[i] = -1;
   endtask

   task automatic write_parent(input int a, input int v);
      pt_we = 1'b1; pt_addr = NODE_W'(a); pt_data = PAR_W'(v);
      step();
      pt_we = 1'b0;
      mdl_par[a] = v;
   endtask

   // Launch one trace and check every hop window and the completion pulse.
   // rmode: 0 always ready, 1 fixed toggle pattern, 2 random.
   // inject: while walking, try a table write and a second start (both must be ignored).
   task automatic run_trace(input int s, input int d, input int rmode, input bit inject);
      int idx, vk, cyc;
      bit got_done, first_seen;
      model(s, d);
      idx = 0; vk = 0; got_done = 1'b0; first_seen = 1'b0; obs_first = -1;
      src = NODE_W'(s); dest = NODE_W'(d); start = 1'b1;
      step();
      start = 1'b0;
      for (cyc = 1; cyc <= 600 && !got_done; cyc++) begin
         if (inject && cyc == 2) begin
            pt_we = 1'b1; pt_addr = NODE_W'(1); pt_data = '1;
            start = 1'b1; src = NODE_W'(5); dest = NODE_W'(5);
         end else if (inject && cyc == 3) begin
            pt_we = 1'b0; start = 1'b0;
         end
         case (rmode)
            0:       hop_ready = 1'b1;
            1:       hop_ready = pat[vk % 6];
            default: hop_ready = 1'($urandom_range(0, 1));
         endcase
         if (hop_valid) begin
            if (!first_seen) begin
               first_seen = 1'b1;
               obs_first = int'(hop_node);
               check("first_hop_latency", cyc, 1 + exp_q.size());
            end
            if (idx >= exp_q.size()) begin
               check("extra_hop_valid", hop_valid, 0);
            end else begin
               check("hop_node", hop_node, exp_q[idx]);
               check("hop_last", hop_last, (idx == exp_q.size() - 1) ? 1 : 0);
               check("hop_count", hop_count, exp_q.size());
            end
            vk++;
            if (hop_ready) idx++;
         end
         if (done) begin
            got_done = 1'b1;
            check("done_err", err, (exp_ec != 0) ? 1 : 0);
            check("done_err_code", err_code, exp_ec);
            check("done_busy", busy, 1);
            check("hops_accepted", idx, exp_q.size());
            obs_ec = int'(err_code);
         end
         step();
      end
      hop_ready = 1'b0;
      pt_we = 1'b0;
      start = 1'b0;
      if (!got_done) begin
         check("trace_timeout", got_done, 1);
         obs_ec = -1;
      end else begin
         check("idle_busy", busy, 0);
         check("done_one_cycle", done, 0);
      end
      obs_cnt = int'(hop_count);
   endtask

   initial begin
      vecs[0] = '{3, 1, 1, 0, 0, 3, 0, 0, 3, 0};
      vecs[1] = '{3, 1, 1, 0, 0, 3, 1, 0, 3, 0};
      vecs[2] = '{-1, 0, -1, 0, 7, 7, 0, 0, 1, 7};
      vecs[3] = '{-1, 0, -1, 0, 0, 3, 0, 1, 0, 0};
      vecs[4] = '{5, 6, 6, 5, 0, 5, 0, 2, 0, 0};
      vecs[5] = '{3, 40, -1, 0, 0, 3, 0, 3, 0, 0};
      vecs[6] = '{9, 4, 4, 2, 2, 9, 2, 0, 3, 2};

      // Reset values.
      do_reset();
      check("rst_hop_valid", hop_valid, 0);
      check("rst_hop_node", hop_node, 0);
      check("rst_hop_last", hop_last, 0);
      check("rst_hop_count", hop_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);

      // Directed vector table.
      for (int i = 0; i < 7; i++) begin
         do_reset();
         if (vecs[i].wa0 >= 0) write_parent(vecs[i].wa0, vecs[i].wv0);
         if (vecs[i].wa1 >= 0) write_parent(vecs[i].wa1, vecs[i].wv1);
         run_trace(vecs[i].s, vecs[i].d, vecs[i].rmode, 1'b0);
         check("vec_err_code", obs_ec, vecs[i].ec);
         check("vec_hop_count", obs_cnt, vecs[i].cnt);
         if (vecs[i].cnt > 0) check("vec_first_hop", obs_first, vecs[i].first);
      end

      // Writes and starts during busy are dropped.
      do_reset();
      write_parent(3, 1);
      write_parent(1, 0);
      run_trace(0, 3, 0, 1'b1);
      check("busy_ignore_ec", obs_ec, 0);
      run_trace(0, 3, 1, 1'b0);
      check("busy_write_dropped", obs_cnt, 3);

      // Reset in the middle of EMIT aborts the trace and clears the table.
      begin
         int w;
         bit seen;
         do_reset();
         write_parent(3, 1);
         write_parent(1, 0);
         src = NODE_W'(0); dest = NODE_W'(3); start = 1'b1;
         step();
         start = 1'b0;
         hop_ready = 1'b1;
         seen = 1'b0;
         for (w = 0; w < 20 && !seen; w++) begin
            if (hop_valid) seen = 1'b1;
            step();
         end
         check("mid_emit_reached", seen, 1);
         check("mid_emit_second_hop", hop_node, 1);
         reset = 1'b1;
         step();
         check("abort_hop_valid", hop_valid, 0);
         check("abort_busy", busy, 0);
         check("abort_done", done, 0);
         reset = 1'b0;
         hop_ready = 1'b0;
         for (int i = 0; i < N_NODES; i++) mdl_par[i] = -1;
         step();
         check("abort_no_late_done", done, 0);
         run_trace(0, 3, 0, 1'b0);
         check("abort_table_cleared", obs_ec, 1);
      end

      // Randomized tables: a chain toward src plus noise entries.
      do_reset();
      for (int r = 0; r < 40; r++) begin
         int len, s, d, nw, v;
         int nodes [$];
         if (r % 10 == 9) do_reset();
         len = $urandom_range(1, 12);
         nodes.delete();
         for (int k = 0; k < len; k++) nodes.push_back($urandom_range(0, N_NODES - 1));
         d = nodes[0];
         s = nodes[len - 1];
         for (int k = 0; k < len - 1; k++) write_parent(nodes[k], nodes[k + 1]);
         nw = $urandom_range(0, 3);
         for (int k = 0; k < nw; k++) begin
            v = $urandom_range(0, 9);
            if (v == 0) v = -1;
            else if (v == 1) v = N_NODES + $urandom_range(0, 20);
            else v = $urandom_range(0, N_NODES - 1);
            write_parent($urandom_range(0, N_NODES - 1), v);
         end
         if ($urandom_range(0, 3) == 0) s = $urandom_range(0, N_NODES - 1);
         run_trace(s, d, 2, 1'b0);
         check("rand_err_code", obs_ec, exp_ec);
         check("rand_hop_count", obs_cnt, exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/route_path_tracer.md
Name: route_path_tracer

Overview:
- Reads back the predecessor (parent) table produced by the shortest-path engine and turns it into an ordered hop list, src first, dest last.
- Walks parent links from dest toward src into an internal LIFO, then streams hops out over a valid/ready interface.
- Sits between the Dijkstra engine (table writer) and the downstream route programmer (hop consumer).

Parameters:
- N_NODES, 32, number of graph nodes and parent-table depth.
- NODE_W, 5, node index width (log2 N_NODES).
- PAR_W, 32, parent entry width; signed, with -1 meaning "no parent".

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pt_we  in  1  parent-table write strobe
- pt_addr  in  NODE_W  parent-table write index
- pt_data  in  PAR_W  signed parent value to write
- start  in  1  begin trace; sampled only in IDLE
- src  in  NODE_W  source node, captured on start
- dest  in  NODE_W  destination node, captured on start
- hop_valid  out  1  hop_node is valid
- hop_ready  in  1  consumer accepts hop
- hop_node  out  NODE_W  current hop
- hop_last  out  1  marks the final hop (dest)
- hop_count  out  NODE_W+1  path length in nodes, valid from first hop_valid until next start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at trace completion, success or error
- err  out  1  trace failed; held until next accepted start
- err_code  out  2  0 none, 1 no_path, 2 loop, 3 bad_node

Behaviour:
- Reset:
  - state IDLE; all outputs 0.
  - All N_NODES parent entries set to -1; stack pointer and depth cleared.
  - Reset asserted mid-trace aborts the trace immediately: no done pulse, no further hops.
- Table writes:
  - Accepted on pt_we only while busy=0; dropped while busy=1.
  - Written data becomes readable the next cycle.
- IDLE:
  - On start, capture src/dest, set cur=dest, clear depth, err and err_code, then go to WALK.
  - start while busy=1 is ignored.
- WALK (one node per cycle), checks in this priority order:
  - depth==N_NODES: err_code=2 (loop), go to FIN.
  - Otherwise push cur and increment depth.
  - If cur==src, go to EMIT.
  - Else read p=parent[cur]:
    - p<0: err_code=1 (no_path), go to FIN.
    - p>=N_NODES: err_code=3 (bad_node), go to FIN.
    - Otherwise cur=p[NODE_W-1:0].
- Latency: start sampled in cycle t; a path of L nodes gives first hop_valid in cycle t+1+L.
- EMIT:
  - hop_node = stack top; hop_valid=1; hop_last=1 when exactly one entry remains; hop_count=depth.
  - Pop on hop_valid & hop_ready.
  - hop_node and hop_last hold stable while hop_valid=1 and hop_ready=0.
  - After the last pop, go to FIN.
  - Back-to-back acceptance gives one hop per cycle.
- FIN:
  - done=1 for one cycle; err=1 if err_code!=0; busy=1.
  - Next cycle returns to IDLE (busy=0).
  - On error no hops are emitted and stack contents are discarded.
- src==dest: WALK takes one cycle; a single hop is emitted with hop_last=1 and hop_count=1.
- The stack holds N_NODES entries and never overflows, because the loop check precedes the push.

Test Plan:
- Write parent[3]=1, parent[1]=0; start src=0 dest=3; hop_ready=1 -> first hop_valid 4 cycles after start (L=3); hops 0,1,3 on consecutive cycles; hop_last only on 3; hop_count=3; done pulse; err=0.
- Same path, hop_ready toggling 1,0,0,1,0,1 -> hops 0,1,3 in order; no drops or duplicates; hop_node and hop_last stable while stalled.
- src=dest=7 -> single hop 7 with hop_last=1, hop_count=1, done, err=0.
- parent[3]=-1 (reset default); start src=0 dest=3 -> no hop_valid; done with err=1, err_code=1.
- parent[5]=6, parent[6]=5; start src=0 dest=5 -> after 32 WALK cycles done with err_code=2, no hops. Separately, parent[3]=40 with dest=3 -> err_code=3.
- Assert reset during EMIT after the first hop -> next cycle hop_valid=0, busy=0, parent[3] reads -1; pt_we during busy is dropped; start during busy is ignored.
